// File: rtl/vec_wb_pkg.sv
// Shared types and constants for the vector register file write-back arbiter.
//   wb_state_e : write-back sequencer states
//   wb_src_e   : requester identity (EXE / LSU)
//   LMUL_*     : one-hot LMUL encodings understood by the register file
//   DEFAULT_TIMEOUT : default DRIVE-cycle budget before a write is declared failed
package vec_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } wb_state_e;

  typedef enum logic {
    SRC_EXE = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  localparam logic [3:0] LMUL_1 = 4'b0001;
  localparam logic [3:0] LMUL_2 = 4'b0010;
  localparam logic [3:0] LMUL_4 = 4'b0100;
  localparam logic [3:0] LMUL_8 = 4'b1000;

  localparam int DEFAULT_TIMEOUT = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
//   i_req[0]     : EXE request      i_req[1] : LSU request
//   i_last_grant : source granted most recently (0=EXE, 1=LSU)
//   o_grant      : one-hot grant, bit order matches i_req; zero when no request
module rr_arb2
  import vec_wb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    // On contention, favour whichever source did not win last time.
    if (i_req == 2'b11) begin
      o_grant = (i_last_grant == SRC_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/vec_wb_arbiter.sv
// Write-back arbiter/sequencer for the vector register file write port.
// Shares one write port between EXE (arithmetic + mask results) and LSU (load data).
// A granted write is held on the rf_* port until the register file reports
// completion or a bad address, or until TIMEOUT DRIVE cycles elapse; the requester
// then sees a one-cycle wb_done or wb_err pulse tagged with wb_src.
//   clk, reset            : clock, synchronous active-low reset
//   exe_* / lsu_*         : valid/ready request channels with write payload
//   rf_*                  : register file write port (zero outside DRIVE)
//   rf_data_written/rf_wrong_addr : register file status
//   wb_done/wb_err/wb_src : completion pulse and its source
//   busy                  : sequencer not idle
module vec_wb_arbiter
  import vec_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int VLEN       = 512,
  parameter int DATA_WIDTH = 8 * VLEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exe_valid,
  output logic                  exe_ready,
  input  logic [ADDR_WIDTH-1:0] exe_waddr,
  input  logic [DATA_WIDTH-1:0] exe_wdata,
  input  logic [3:0]            exe_lmul,
  input  logic                  exe_mask_wr,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_lmul,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [3:0]            rf_lmul,
  output logic                  rf_wr_en,
  output logic                  rf_mask_wr_en,
  input  logic                  rf_data_written,
  input  logic                  rf_wrong_addr,
  output logic                  wb_done,
  output logic                  wb_err,
  output logic                  wb_src,
  output logic                  busy
);

  localparam int CntW = $clog2(TIMEOUT) + 1;

  wb_state_e             r_state;
  logic                  r_last_grant;
  logic [CntW-1:0]       r_cnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_lmul;
  logic                  r_mask;
  logic                  r_src;

  logic [1:0] w_grant;
  logic       w_idle;
  logic       w_drive;
  logic       w_sel_lsu;

  rr_arb2 u_arb (
    .i_req        ({lsu_valid, exe_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_idle    = (r_state == IDLE);
  assign w_drive   = (r_state == DRIVE);
  assign w_sel_lsu = w_grant[1];

  assign exe_ready = w_idle & w_grant[0];
  assign lsu_ready = w_idle & w_grant[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= SRC_LSU;
      r_cnt        <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_lmul       <= '0;
      r_mask       <= 1'b0;
      r_src        <= SRC_EXE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_waddr      <= w_sel_lsu ? lsu_waddr : exe_waddr;
            r_wdata      <= w_sel_lsu ? lsu_wdata : exe_wdata;
            r_lmul       <= w_sel_lsu ? lsu_lmul  : exe_lmul;
            // Loads never update the v0 mask through the mask port.
            r_mask       <= w_sel_lsu ? 1'b0 : exe_mask_wr;
            r_src        <= w_sel_lsu ? SRC_LSU : SRC_EXE;
            r_last_grant <= w_sel_lsu ? SRC_LSU : SRC_EXE;
            r_cnt        <= '0;
            r_state      <= DRIVE;
          end
        end
        DRIVE: begin
          // Leaves DRIVE no later than count TIMEOUT-1, so this cannot wrap.
          r_cnt <= r_cnt + CntW'(1);
          if (rf_data_written) begin
            r_state <= DONE;
          end else if (rf_wrong_addr) begin
            r_state <= ERR;
          end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
            // Catches illegal lmul, for which the register file stays silent.
            r_state <= ERR;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_waddr      = w_drive ? r_waddr : '0;
  assign rf_wdata      = w_drive ? r_wdata : '0;
  assign rf_lmul       = w_drive ? r_lmul  : '0;
  assign rf_wr_en      = w_drive & ~r_mask;
  assign rf_mask_wr_en = w_drive & r_mask;

  assign wb_done = (r_state == DONE);
  assign wb_err  = (r_state == ERR);
  assign wb_src  = (wb_done | wb_err) & r_src;
  assign busy    = ~w_idle;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Self-checking bench for vec_wb_arbiter: directed cases plus randomized batches
// checked against a transaction-level model of arbitration and write outcome.
module tb_vec_wb_arbiter;
  import vec_wb_pkg::*;

  localparam int AW   = 5;
  localparam int VLEN = 512;
  localparam int DW   = 8 * VLEN;
  localparam int TO   = 4;

  // Response kinds for the register file model.
  localparam int RespWritten = 0;
  localparam int RespBadAddr = 1;
  localparam int RespNever   = 2;
  localparam int RespBoth    = 3;

  logic          clk;
  logic          reset;
  logic          exe_valid, exe_ready, exe_mask_wr;
  logic [AW-1:0] exe_waddr;
  logic [DW-1:0] exe_wdata;
  logic [3:0]    exe_lmul;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_lmul;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    rf_lmul;
  logic          rf_wr_en, rf_mask_wr_en, rf_data_written, rf_wrong_addr;
  logic          wb_done, wb_err, wb_src, busy;

  vec_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .VLEN       (VLEN),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .exe_valid       (exe_valid),
    .exe_ready       (exe_ready),
    .exe_waddr       (exe_waddr),
    .exe_wdata       (exe_wdata),
    .exe_lmul        (exe_lmul),
    .exe_mask_wr     (exe_mask_wr),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_waddr       (lsu_waddr),
    .lsu_wdata       (lsu_wdata),
    .lsu_lmul        (lsu_lmul),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .rf_lmul         (rf_lmul),
    .rf_wr_en        (rf_wr_en),
    .rf_mask_wr_en   (rf_mask_wr_en),
    .rf_data_written (rf_data_written),
    .rf_wrong_addr   (rf_wrong_addr),
    .wb_done         (wb_done),
    .wb_err          (wb_err),
    .wb_src          (wb_src),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int m_last   = 1;  // model of last granted source: 0=EXE, 1=LSU

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [3:0] rand_lmul();
    logic [3:0] t;
    t = 4'b0001 << $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) t = 4'($urandom);
    return t;
  endfunction

  // Outputs that must be quiet when no write is being driven or reported.
  task automatic check_quiet(input string tag);
    check_eq({tag, "_rf"}, 64'({rf_wr_en, rf_mask_wr_en, rf_waddr, rf_lmul, |rf_wdata}), 64'd0);
    check_eq({tag, "_wb"}, 64'({wb_done, wb_err, wb_src}), 64'd0);
  endtask

  // Presents one or both requests and follows every resulting write to completion.
  // Expectations come from: round-robin on contention, outcome decided by the first
  // register file response within TO drive cycles, otherwise a timeout error.
  task automatic run_batch(input logic ev, input logic lv,
                           input logic [AW-1:0] ea, input logic [3:0] el, input logic em,
                           input logic [DW-1:0] ed,
                           input logic [AW-1:0] la, input logic [3:0] ll, input logic [DW-1:0] ld,
                           input int ekind, input int ek, input int lkind, input int lk);
    logic          pend [2];
    int            g, kind, k, n_drive;
    logic          exp_err;
    logic [AW-1:0] x_addr;
    logic [3:0]    x_lmul;
    logic [DW-1:0] x_data;
    logic          x_mask;
    pend[0] = ev;
    pend[1] = lv;
    exe_valid = ev; exe_waddr = ea; exe_lmul = el; exe_mask_wr = em; exe_wdata = ed;
    lsu_valid = lv; lsu_waddr = la; lsu_lmul = ll; lsu_wdata = ld;
    while (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) g = (m_last == 0) ? 1 : 0;
      else g = pend[0] ? 0 : 1;
      m_last = g;
      kind   = (g == 1) ? lkind : ekind;
      k      = (g == 1) ? lk : ek;
      if (kind != RespNever && k <= TO) begin
        n_drive = k;
        exp_err = (kind == RespBadAddr);
      end else begin
        n_drive = TO;
        exp_err = 1'b1;
      end
      x_addr = (g == 1) ? la : ea;
      x_lmul = (g == 1) ? ll : el;
      x_data = (g == 1) ? ld : ed;
      x_mask = (g == 1) ? 1'b0 : em;

      @(negedge clk);
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("exe_ready", 64'(exe_ready), 64'(g == 0));
      check_eq("lsu_ready", 64'(lsu_ready), 64'(g == 1));
      check_quiet("idle");
      @(posedge clk); #1;
      if (g == 0) exe_valid = 1'b0;
      else lsu_valid = 1'b0;

      for (int d = 1; d <= n_drive; d++) begin
        @(negedge clk);
        check_eq("drv_busy", 64'(busy), 64'd1);
        check_eq("drv_ready", 64'({exe_ready, lsu_ready}), 64'd0);
        check_eq("drv_waddr", 64'(rf_waddr), 64'(x_addr));
        check_eq("drv_lmul", 64'(rf_lmul), 64'(x_lmul));
        check_eq("drv_wdata_lo", 64'(rf_wdata[31:0]), 64'(x_data[31:0]));
        check_eq("drv_wdata_eq", 64'(rf_wdata === x_data), 64'd1);
        check_eq("drv_wr_en", 64'(rf_wr_en), 64'(!x_mask));
        check_eq("drv_mask_wr_en", 64'(rf_mask_wr_en), 64'(x_mask));
        check_eq("drv_wb", 64'({wb_done, wb_err}), 64'd0);
        rf_data_written = (kind == RespWritten || kind == RespBoth) && (d == k);
        rf_wrong_addr   = (kind == RespBadAddr || kind == RespBoth) && (d == k);
        @(posedge clk); #1;
        rf_data_written = 1'b0;
        rf_wrong_addr   = 1'b0;
      end

      @(negedge clk);
      check_eq("end_done", 64'(wb_done), 64'(!exp_err));
      check_eq("end_err", 64'(wb_err), 64'(exp_err));
      check_eq("end_src", 64'(wb_src), 64'(g));
      check_eq("end_busy", 64'(busy), 64'd1);
      check_eq("end_rf", 64'({rf_wr_en, rf_mask_wr_en}), 64'd0);
      @(posedge clk); #1;
      pend[g] = 1'b0;
    end
  endtask

  logic [DW-1:0] pat_a5;

  initial begin
    reset = 1'b0;
    exe_valid = 1'b0; exe_waddr = '0; exe_wdata = '0; exe_lmul = '0; exe_mask_wr = 1'b0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0; lsu_lmul = '0;
    rf_data_written = 1'b0; rf_wrong_addr = 1'b0;
    for (int i = 0; i < DW / 8; i++) pat_a5[i*8 +: 8] = 8'hA5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'({exe_ready, lsu_ready}), 64'd0);
    check_quiet("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    m_last = 1;

    // Contention right after reset: EXE first, LSU three cycles later.
    run_batch(1'b1, 1'b1, 5'd1, LMUL_1, 1'b0, rand_data(), 5'd2, LMUL_1, rand_data(),
              RespWritten, 1, RespWritten, 1);
    // Single EXE write, completes in the first DRIVE cycle.
    run_batch(1'b1, 1'b0, 5'd4, LMUL_1, 1'b0, pat_a5, 5'd0, LMUL_1, '0,
              RespWritten, 1, RespNever, 1);
    // v0 mask update.
    run_batch(1'b1, 1'b0, 5'd0, LMUL_1, 1'b1, rand_data(), 5'd0, LMUL_1, '0,
              RespWritten, 1, RespNever, 1);
    // LSU write rejected by the register file.
    run_batch(1'b0, 1'b1, 5'd0, LMUL_1, 1'b0, '0, 5'd3, LMUL_2, rand_data(),
              RespNever, 1, RespBadAddr, 1);
    // Illegal lmul, silent register file: timeout after TO drive cycles.
    run_batch(1'b1, 1'b0, 5'd8, 4'b0011, 1'b0, rand_data(), 5'd0, LMUL_1, '0,
              RespNever, 1, RespNever, 1);
    // Both status bits at once: completion wins.
    run_batch(1'b0, 1'b1, 5'd0, LMUL_1, 1'b0, '0, 5'd16, LMUL_8, rand_data(),
              RespNever, 1, RespBoth, 2);

    // Reset in the second DRIVE cycle abandons the write silently.
    exe_valid = 1'b1; exe_waddr = 5'd6; exe_lmul = LMUL_4; exe_mask_wr = 1'b0;
    exe_wdata = rand_data();
    @(negedge clk);
    check_eq("rstdrv_accept", 64'(exe_ready), 64'd1);
    @(posedge clk); #1;
    exe_valid = 1'b0;
    @(negedge clk);
    check_eq("rstdrv_d1_wr_en", 64'(rf_wr_en), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstdrv_d2_wr_en", 64'(rf_wr_en), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_last = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rstdrv_busy", 64'(busy), 64'd0);
      check_quiet("rstdrv");
      @(posedge clk); #1;
    end
    run_batch(1'b1, 1'b1, 5'd9, LMUL_2, 1'b0, rand_data(), 5'd10, LMUL_2, rand_data(),
              RespWritten, 2, RespBadAddr, 3);

    // Randomized batches.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic ev, lv;
      r  = $urandom_range(1, 3);
      ev = r[0];
      lv = r[1];
      run_batch(ev, lv, 5'($urandom), rand_lmul(), 1'($urandom), rand_data(),
                5'($urandom), rand_lmul(), rand_data(),
                $urandom_range(0, 3), $urandom_range(1, TO + 1),
                $urandom_range(0, 3), $urandom_range(1, TO + 1));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_eq("gap_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    check_eq("final_busy", 64'(busy), 64'd0);
    check_quiet("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
